operand_accumulator: RTL and testbench
======================================

// Module: operand_accumulator
// PURPOSE
//   Downstream consumer of the Adder: sums a burst of signed OPERAND_BIT operands
//   into a wider ACC_BIT running total, one operand per cycle, using one Adder
//   instance (OPERAND_BIT=ACC_BIT, Cin=0) as its datapath. Sits between operand
//   sources and the result path of the ArithmeticOperator block.
// PARAMETERS
//   OPERAND_BIT  10  width of each two's-complement input operand
//   ACC_BIT      16  accumulator/result width; must be >= OPERAND_BIT
//   COUNT_BIT     4  width of the term counter; a burst holds 0..2^COUNT_BIT-1 terms
// PORTS
//   clk           in   1            rising-edge clock
//   rst_n         in   1            asynchronous active-low reset
//   start         in   1            begin a burst; sampled only in IDLE
//   num_terms     in   COUNT_BIT    number of operands in the burst, latched with start
//   in_valid      in   1            in_data valid
//   in_ready      out  1            block accepts in_data this cycle
//   in_data       in   OPERAND_BIT  signed operand
//   out_valid     out  1            out_sum/out_overflow valid
//   out_ready     in   1            consumer takes result
//   out_sum       out  ACC_BIT      signed sum, wrap-around (no saturation)
//   out_overflow  out  1            sticky: signed overflow occurred during burst
//   busy          out  1            high in ACCUM and DONE
// BEHAVIOUR
//   - Reset (rst_n=0, any time, async): state=IDLE; acc, count, terms_q, ovf = 0;
//     in_ready=0, out_valid=0, out_sum=0, out_overflow=0, busy=0. An in-flight burst
//     is discarded; no partial result is emitted after reset release.
//   - FSM states IDLE, ACCUM, DONE:
//     IDLE : in_ready=0. On start: latch num_terms, clear acc/count/ovf;
//            num_terms==0 -> DONE (out_sum=0, out_overflow=0); else -> ACCUM.
//     ACCUM: in_ready=1. Accept when in_valid&&in_ready: acc <= Adder.S of
//            (acc, sign-extended in_data), count <= count+1. Accept of the term
//            with count==terms_q-1 -> DONE. in_valid low = bubble, state held.
//     DONE : out_valid=1, out_sum=acc, out_overflow=ovf, held stable until
//            out_ready=1; that cycle -> IDLE. out_valid may not drop without out_ready.
//   - start outside IDLE is ignored; num_terms changes outside IDLE have no effect.
//   - Throughput 1 operand/cycle; out_valid rises the cycle after the last accept.
//     start -> first possible accept: 1 cycle. out_ready -> next start accepted: 1 cycle.
//   - Overflow: per add, ovf |= (sign(acc)==sign(ext_in)) && (sign(S)!=sign(acc));
//     Adder.Cout is unused for signed overflow. acc keeps wrapped value.
//   - in_ready and out_valid are purely state-decoded (registered state), no
//     combinational path from in_valid/out_ready to in_ready/out_valid.
// TESTING
//   1. start, num_terms=2, in_data=-184 then 471 -> out_valid next cycle after 2nd
//      accept, out_sum=287, out_overflow=0.
//   2. num_terms=3, in_valid low 2 cycles between terms 5,-7,10 -> in_ready held high,
//      out_sum=8; result held unchanged while out_ready low for 5 cycles.
//   3. ACC_BIT=10 override, num_terms=2, 300+300 -> out_sum=-424 (0x258), out_overflow=1.
//   4. num_terms=0 start -> out_valid one cycle later, out_sum=0, no in_ready pulse.
//   5. rst_n low after 1 of 3 terms -> all outputs 0 immediately; new burst 1+2 -> 3.
//   6. start pulsed during ACCUM/DONE -> ignored; 15 terms of 511 -> out_sum=7665, ovf=0.

Source files
------------

// File: rtl/operand_accumulator.sv
// -----------------------------------------------------------------------------
// operand_accumulator
//   Sums a burst of signed operands into a wider running total, one operand
//   per cycle. A single adder instance forms the datapath.
//   A burst starts with start/num_terms in IDLE. Operands are taken over a
//   valid/ready handshake in ACCUM. The wrapped sum and a sticky signed-overflow
//   flag are then presented in DONE until the consumer takes them.
//
// Parameters
//   OPERAND_BIT  width of each two's-complement input operand
//   ACC_BIT      accumulator/result width (>= OPERAND_BIT)
//   COUNT_BIT    width of the term counter (0..2^COUNT_BIT-1 terms per burst)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a burst; only looked at in IDLE
//   num_terms     operand count of the burst, captured together with start
//   in_valid      in_data carries an operand
//   in_ready      block accepts in_data this cycle
//   in_data       signed operand
//   out_valid     out_sum/out_overflow are valid
//   out_ready     consumer takes the result
//   out_sum       signed wrap-around sum of the burst
//   out_overflow  signed overflow happened at least once during the burst
//   busy          a burst is being accumulated or its result is pending
// -----------------------------------------------------------------------------
module operand_accumulator #(
  parameter int OPERAND_BIT = 10,
  parameter int ACC_BIT     = 16,
  parameter int COUNT_BIT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_BIT-1:0]   num_terms,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPERAND_BIT-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_BIT-1:0]     out_sum,
  output logic                   out_overflow,
  output logic                   busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [ACC_BIT-1:0]   acc;
  logic [COUNT_BIT-1:0] count;
  logic [COUNT_BIT-1:0] terms_q;
  logic                 ovf;

  logic [ACC_BIT-1:0]   ext_in;
  logic [ACC_BIT-1:0]   add_sum;
  logic                 adder_cout_unused;
  logic                 add_ovf;
  logic                 accept;
  logic                 last_term;

  // Sign-extend through a signed cast so that ACC_BIT == OPERAND_BIT also works.
  assign ext_in = ACC_BIT'(signed'(in_data));

  adder #(
    .OPERAND_BIT(ACC_BIT)
  ) u_adder (
    .a   (acc),
    .b   (ext_in),
    .cin (1'b0),
    .s   (add_sum),
    .cout(adder_cout_unused)
  );

  // Signed overflow comes from the operand and result signs. The adder's
  // carry out only describes unsigned overflow, so it is not used.
  assign add_ovf = (acc[ACC_BIT-1] == ext_in[ACC_BIT-1]) &&
                   (add_sum[ACC_BIT-1] != acc[ACC_BIT-1]);

  // Handshake outputs come only from the registered state. This keeps
  // in_valid/out_ready from reaching them combinationally.
  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == DONE);
  assign busy         = (state == ACCUM) || (state == DONE);
  assign out_sum      = (state == DONE) ? acc : '0;
  assign out_overflow = (state == DONE) ? ovf : 1'b0;

  assign accept    = in_valid && in_ready;
  assign last_term = (count == terms_q - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      terms_q <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            terms_q <= num_terms;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            state   <= (num_terms == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= add_sum;
            count <= count + 1'b1;
            ovf   <= ovf | add_ovf;
            if (last_term) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// -----------------------------------------------------------------------------
// adder
//   Plain ripple-style binary adder: {cout, s} = a + b + cin.
//
// Ports
//   a, b  addends
//   cin   carry in
//   s     sum
//   cout  carry out
// -----------------------------------------------------------------------------
module adder #(
  parameter int OPERAND_BIT = 16
) (
  input  logic [OPERAND_BIT-1:0] a,
  input  logic [OPERAND_BIT-1:0] b,
  input  logic                   cin,
  output logic [OPERAND_BIT-1:0] s,
  output logic                   cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{OPERAND_BIT{1'b0}}, cin};

endmodule

// File: tb/tb_operand_accumulator.sv
// -----------------------------------------------------------------------------
// tb_operand_accumulator
//   Self-checking bench for operand_accumulator. It uses a table of bursts,
//   and each burst holds its operands and its expected result. The expected
//   result goes into a scoreboard queue when the burst is driven. It is popped
//   and compared when the DUT presents out_valid. Hand-written sequences cover
//   the narrow-accumulator overflow case and a reset during a burst.
// -----------------------------------------------------------------------------
module tb_operand_accumulator;

  typedef struct packed {
    logic [3:0]       n;
    logic [14:0][9:0] terms;
    logic [2:0]       bubbles;
    logic [2:0]       hold;
    logic             pulse;
    logic [15:0]      exp_sum;
    logic             exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  num_terms;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_overflow;
  logic        busy;

  // Second instance with a 10-bit accumulator, for the overflow case
  logic        n_start;
  logic [3:0]  n_num_terms;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [9:0]  n_in_data;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [9:0]  n_out_sum;
  logic        n_out_overflow;
  logic        n_busy;

  int   assertions;
  int   failures;
  res_t exp_q[$];
  vec_t vecs[7];

  operand_accumulator #(.OPERAND_BIT(10), .ACC_BIT(16), .COUNT_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .busy(busy)
  );

  operand_accumulator #(.OPERAND_BIT(10), .ACC_BIT(10), .COUNT_BIT(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .start(n_start), .num_terms(n_num_terms),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_sum(n_out_sum),
    .out_overflow(n_out_overflow), .busy(n_busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one burst on the main instance. The expected result goes into the
  // scoreboard, then it is popped and compared when out_valid shows up. All
  // driving and sampling is done on the falling edge.
  task automatic apply_stimulus(input vec_t v);
    res_t exp_r;
    int   waited;
    exp_r.sum = v.exp_sum;
    exp_r.ovf = v.exp_ovf;
    exp_q.push_back(exp_r);

    @(negedge clk);
    start     = 1'b1;
    num_terms = v.n;
    @(negedge clk);
    start     = 1'b0;
    num_terms = 4'($urandom_range(0, 15));
    check_output("in_ready_after_start", 32'(in_ready), 32'(v.n != 4'd0));
    check_output("busy_after_start", 32'(busy), 32'd1);

    for (int i = 0; i < int'(v.n); i++) begin
      in_valid = 1'b1;
      in_data  = v.terms[i];
      if (v.pulse) begin
        start     = 1'b1;
        num_terms = 4'd1;
      end
      check_output("in_ready_accum", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = 10'($urandom);
      if (i != int'(v.n) - 1) begin
        for (int b = 0; b < int'(v.bubbles); b++) begin
          check_output("in_ready_bubble", 32'(in_ready), 32'd1);
          check_output("out_valid_bubble", 32'(out_valid), 32'd0);
          @(negedge clk);
        end
      end
    end

    // The result must be presented in the cycle after the last accept
    check_output("out_valid_latency", 32'(out_valid), 32'd1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    exp_r = exp_q.pop_front();
    check_output("out_sum", 32'(out_sum), 32'(exp_r.sum));
    check_output("out_overflow", 32'(out_overflow), 32'(exp_r.ovf));
    check_output("in_ready_done", 32'(in_ready), 32'd0);

    for (int h = 0; h < int'(v.hold); h++) begin
      out_ready = 1'b0;
      if (v.pulse) begin
        start     = 1'b1;
        num_terms = 4'd3;
      end
      @(negedge clk);
      check_output("out_valid_hold", 32'(out_valid), 32'd1);
      check_output("out_sum_hold", 32'(out_sum), 32'(exp_r.sum));
    end

    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("out_valid_after_take", 32'(out_valid), 32'd0);
    check_output("busy_after_take", 32'(busy), 32'd0);
  endtask

  initial begin
    assertions  = 0;
    failures    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    num_terms   = 4'd0;
    in_valid    = 1'b0;
    in_data     = 10'd0;
    out_ready   = 1'b0;
    n_start     = 1'b0;
    n_num_terms = 4'd0;
    n_in_valid  = 1'b0;
    n_in_data   = 10'd0;
    n_out_ready = 1'b0;

    // Burst table: operands with hand-computed sums
    for (int k = 0; k < 7; k++) vecs[k] = '0;
    vecs[0].n = 4'd2; vecs[0].terms[0] = 10'(-184); vecs[0].terms[1] = 10'd471;
    vecs[0].exp_sum = 16'd287;
    vecs[1].n = 4'd3; vecs[1].terms[0] = 10'd5; vecs[1].terms[1] = 10'(-7);
    vecs[1].terms[2] = 10'd10; vecs[1].bubbles = 3'd2; vecs[1].hold = 3'd5;
    vecs[1].exp_sum = 16'd8;
    vecs[2].n = 4'd0; vecs[2].exp_sum = 16'd0;
    vecs[3].n = 4'd15; vecs[3].pulse = 1'b1; vecs[3].hold = 3'd2;
    for (int k = 0; k < 15; k++) vecs[3].terms[k] = 10'd511;
    vecs[3].exp_sum = 16'd7665;
    vecs[4].n = 4'd4; vecs[4].hold = 3'd1;
    for (int k = 0; k < 4; k++) vecs[4].terms[k] = 10'(-512);
    vecs[4].exp_sum = 16'hF800;
    vecs[5].n = 4'd1; vecs[5].terms[0] = 10'(-1); vecs[5].exp_sum = 16'hFFFF;
    vecs[6].n = 4'd2; vecs[6].terms[0] = 10'd1; vecs[6].terms[1] = 10'd2;
    vecs[6].exp_sum = 16'd3;

    repeat (3) @(negedge clk);
    check_output("reset_in_ready", 32'(in_ready), 32'd0);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_sum", 32'(out_sum), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) apply_stimulus(vecs[k]);

    // Narrow accumulator: 300 + 300 wraps to -424 and sets overflow
    @(negedge clk);
    n_start     = 1'b1;
    n_num_terms = 4'd2;
    @(negedge clk);
    n_start    = 1'b0;
    n_in_valid = 1'b1;
    n_in_data  = 10'd300;
    @(negedge clk);
    @(negedge clk);
    n_in_valid = 1'b0;
    check_output("narrow_out_valid", 32'(n_out_valid), 32'd1);
    check_output("narrow_out_sum", 32'(n_out_sum), 32'h258);
    check_output("narrow_out_overflow", 32'(n_out_overflow), 32'd1);
    n_out_ready = 1'b1;
    @(negedge clk);
    n_out_ready = 1'b0;
    check_output("narrow_idle", 32'(n_busy), 32'd0);

    // Reset in the middle of a burst discards it
    start     = 1'b1;
    num_terms = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 10'd7;
    @(negedge clk);
    in_data = 10'd8;
    rst_n   = 1'b0;
    #1;
    check_output("midreset_in_ready", 32'(in_ready), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_out_valid", 32'(out_valid), 32'd0);
    check_output("midreset_out_sum", 32'(out_sum), 32'd0);
    check_output("midreset_out_overflow", 32'(out_overflow), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("postreset_out_valid", 32'(out_valid), 32'd0);
    end
    apply_stimulus(vecs[6]);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
